// File: rtl/vga_fb_arbiter_pkg.sv
// Shared types for the VGA framebuffer arbiter: RGB333 pixel, clear-FSM states, framebuffer size helper.
package vga_fb_pkg;

   localparam int RGB_W = 9;

   typedef struct packed {
      logic [2:0] r;
      logic [2:0] g;
      logic [2:0] b;
   } rgb333_t;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } fb_state_t;

   function automatic int fb_words(input int w, input int h);
      return w * h;
   endfunction

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Pixel-writer handshake into the framebuffer arbiter (valid/ready, word address, RGB333 data).
interface vga_fb_arbiter_if #(
   parameter int ADDR_W = 15
);
   import vga_fb_pkg::*;

   logic              wrValid;
   logic [ADDR_W-1:0] wrAddr;
   rgb333_t           wrData;
   logic              wrReady;

   modport master (output wrValid, wrAddr, wrData, input wrReady);
   modport slave  (input wrValid, wrAddr, wrData, output wrReady);
endinterface

// File: rtl/vga_fb_arbiter_ram.sv
// Single-port framebuffer RAM: one shared read/write port, synchronous read, 2**ADDR_W x RGB333.
module vga_fb_ram
   import vga_fb_pkg::*;
#(
   parameter int ADDR_W = 15
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_addr,
   input  rgb333_t           i_wdata,
   output rgb333_t           o_rdata
);
   rgb333_t mem_q [2**ADDR_W];
   rgb333_t rdata_q;

   // NOTE: the array has no reset so it maps onto block RAM; contents are defined by the clear FSM.
   always_ff @(posedge i_clk) begin
      if (i_we) mem_q[i_addr] <= i_wdata;
      rdata_q <= mem_q[i_addr];
   end

   assign o_rdata = rdata_q;
endmodule

// File: rtl/vga_fb_arbiter.sv
// VGA framebuffer arbiter: fixed scan-out read slots, writer on free cycles, clear-to-background FSM.
// Optional saturating stall/drop counters when VGA_FB_ARB_STATS_EN is defined.
module vga_fb_arbiter
   import vga_fb_pkg::*;
#(
   parameter int               FB_W      = 160,
   parameter int               FB_H      = 120,
   parameter int               SCALE_LG2 = 2,
   parameter int               ADDR_W    = 15,
   parameter logic [RGB_W-1:0] BG_COLOR  = 9'h000
) (
   input  logic       i_clk,
   input  logic       i_resetN,
   input  logic [9:0] i_px,
   input  logic [9:0] i_py,
   input  logic       i_active,
   input  logic       i_hs,
   input  logic       i_vs,
   output logic       o_hs,
   output logic       o_vs,
   output logic [2:0] o_red,
   output logic [2:0] o_green,
   output logic [2:0] o_blue,
   vga_fb_arbiter_if.slave wr,
   input  logic       i_clear,
   output logic       o_busy
`ifdef VGA_FB_ARB_STATS_EN
   ,
   output logic [15:0] o_stallCnt,
   output logic [15:0] o_dropCnt
`endif
);
   localparam int                FB_WORDS  = fb_words(FB_W, FB_H);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WORDS - 1);

   logic              scan_slot;
   logic [ADDR_W-1:0] scan_addr;
   logic              wr_in_range;

   assign scan_slot   = i_active && (i_px[SCALE_LG2-1:0] == '0);
   assign scan_addr   = ADDR_W'(int'(i_py >> SCALE_LG2) * FB_W + int'(i_px >> SCALE_LG2));
   assign wr_in_range = (int'(wr.wrAddr) < FB_WORDS);

   fb_state_t         state_q, state_d;
   logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk or negedge i_resetN) begin
      if (!i_resetN) begin
         state_q    <= CLEAR;
         clr_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
      end
   end

   // NOTE: defaults first in every always_comb so no path leaves a variable unassigned (no latches).
   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      if (i_clear) begin
         state_d    = CLEAR;
         clr_addr_d = '0;
      end else if (state_q == CLEAR && !scan_slot) begin
         if (clr_addr_q == LAST_ADDR) state_d = RUN;
         else clr_addr_d = clr_addr_q + ADDR_W'(1);
      end
   end

   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   rgb333_t           ram_wdata, ram_rdata;

   // Scan-out owns the port on slot cycles; otherwise the clear FSM or the writer does.
   always_comb begin
      wr.wrReady = (state_q == RUN) && !scan_slot;
      o_busy     = (state_q == CLEAR);
      ram_we     = 1'b0;
      ram_addr   = scan_addr;
      ram_wdata  = rgb333_t'(BG_COLOR);
      if (!scan_slot) begin
         if (state_q == CLEAR) begin
            ram_we   = !i_clear;
            ram_addr = clr_addr_q;
         end else if (wr.wrValid && wr_in_range) begin
            ram_we    = 1'b1;
            ram_addr  = wr.wrAddr;
            ram_wdata = wr.wrData;
         end
      end
   end

   vga_fb_ram #(.ADDR_W(ADDR_W)) u_ram (
      .i_clk   (i_clk),
      .i_we    (ram_we),
      .i_addr  (ram_addr),
      .i_wdata (ram_wdata),
      .o_rdata (ram_rdata)
   );

   logic [1:0] act_q, hs_q, vs_q;
   logic       slot_q;
   rgb333_t    hold_q;

   // Two-stage sync pipe matches the RAM read latency plus the hold register.
   always_ff @(posedge i_clk or negedge i_resetN) begin
      if (!i_resetN) begin
         act_q  <= '0;
         hs_q   <= '0;
         vs_q   <= '0;
         slot_q <= 1'b0;
         hold_q <= '0;
      end else begin
         act_q  <= {act_q[0], i_active};
         hs_q   <= {hs_q[0], i_hs};
         vs_q   <= {vs_q[0], i_vs};
         slot_q <= scan_slot;
         if (slot_q) hold_q <= ram_rdata;
      end
   end

   assign o_hs    = hs_q[1];
   assign o_vs    = vs_q[1];
   assign o_red   = act_q[1] ? hold_q.r : 3'd0;
   assign o_green = act_q[1] ? hold_q.g : 3'd0;
   assign o_blue  = act_q[1] ? hold_q.b : 3'd0;

`ifdef VGA_FB_ARB_STATS_EN
   logic [15:0] stall_cnt_q, drop_cnt_q;

   always_ff @(posedge i_clk or negedge i_resetN) begin
      if (!i_resetN) begin
         stall_cnt_q <= '0;
         drop_cnt_q  <= '0;
      end else if (i_clear) begin
         stall_cnt_q <= '0;
         drop_cnt_q  <= '0;
      end else begin
         if (wr.wrValid && !wr.wrReady && stall_cnt_q != '1)
            stall_cnt_q <= stall_cnt_q + 16'd1;
         if (wr.wrValid && wr.wrReady && !wr_in_range && drop_cnt_q != '1)
            drop_cnt_q <= drop_cnt_q + 16'd1;
      end
   end

   assign o_stallCnt = stall_cnt_q;
   assign o_dropCnt  = drop_cnt_q;
`endif
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter: table vectors, directed corner sequences, random stimulus vs a framebuffer model.
`timescale 1ns/1ps
module tb_vga_fb_arbiter;
   localparam int         FB_W   = 160;
   localparam int         FB_H   = 120;
   localparam int         ADDR_W = 15;
   localparam int         WORDS  = FB_W * FB_H;
   localparam logic [8:0] BG     = 9'h000;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [9:0] px, py;
   logic       active, hs_in, vs_in, clear;
   logic       hs_out, vs_out, busy;
   logic [2:0] red, green, blue;
`ifdef VGA_FB_ARB_STATS_EN
   logic [15:0] stall_cnt, drop_cnt;
`endif

   vga_fb_arbiter_if #(.ADDR_W(ADDR_W)) wr_if ();

   vga_fb_arbiter #(.FB_W(FB_W), .FB_H(FB_H), .SCALE_LG2(2), .ADDR_W(ADDR_W), .BG_COLOR(BG)) dut (
      .i_clk (clk), .i_resetN (rst_n), .i_px (px), .i_py (py), .i_active (active),
      .i_hs (hs_in), .i_vs (vs_in), .o_hs (hs_out), .o_vs (vs_out),
      .o_red (red), .o_green (green), .o_blue (blue), .wr (wr_if.slave),
      .i_clear (clear), .o_busy (busy)
`ifdef VGA_FB_ARB_STATS_EN
      , .o_stallCnt (stall_cnt), .o_dropCnt (drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Reference model: framebuffer contents with a known-flag per word, clear progress, counters,
   // and short histories of what the screen should show two clocks later.
   logic [8:0] m_fb [WORDS];
   bit         m_known [WORDS];
   bit         m_busy;
   int         m_clr, m_stall, m_drop;
   bit         act_h1, act_h2, hs_h1, hs_h2, vs_h1, vs_h2;
   logic [8:0] l_cur, l_h1, l_h2;
   bit         lk_cur, lk_h1, lk_h2;
   bit         last_ready, last_busy;
   logic [8:0] last_rgb;

   task automatic model_reset();
      m_busy = 1; m_clr = 0; m_stall = 0; m_drop = 0;
      act_h1 = 0; act_h2 = 0; hs_h1 = 0; hs_h2 = 0; vs_h1 = 0; vs_h2 = 0;
      l_cur = '0; l_h1 = '0; l_h2 = '0; lk_cur = 1; lk_h1 = 1; lk_h2 = 1;
      foreach (m_known[i]) m_known[i] = 0;
   endtask

   // One clock: compare outputs at the falling edge, advance the model, return just after the rising edge.
   task automatic cycle();
      bit slot;
      int saddr;
      @(negedge clk);
      slot       = active && (px[1:0] == 2'd0);
      last_ready = wr_if.wrReady;
      last_busy  = busy;
      last_rgb   = {red, green, blue};
      check("wr_ready", wr_if.wrReady, !m_busy && !slot);
      check("busy", busy, m_busy);
      check("hs", hs_out, hs_h2);
      check("vs", vs_out, vs_h2);
      if (!act_h2) check("rgb_blank", last_rgb, 9'h000);
      else if (lk_h2) check("rgb", last_rgb, l_h2);
`ifdef VGA_FB_ARB_STATS_EN
      check("stall_cnt", stall_cnt, m_stall);
      check("drop_cnt", drop_cnt, m_drop);
`endif
      if (slot) begin
         saddr = (int'(py) / 4) * FB_W + int'(px) / 4;
         if (saddr < WORDS) begin
            l_cur = m_fb[saddr]; lk_cur = m_known[saddr];
         end else lk_cur = 0;
      end
      if (wr_if.wrValid && (m_busy || slot) && m_stall < 65535) m_stall++;
      if (m_busy) begin
         if (clear) begin
            if (!slot) m_known[m_clr] = 0;
            m_clr = 0;
         end else if (!slot) begin
            m_fb[m_clr] = BG; m_known[m_clr] = 1; m_clr++;
            if (m_clr == WORDS) m_busy = 0;
         end
      end else begin
         if (wr_if.wrValid && !slot) begin
            if (int'(wr_if.wrAddr) < WORDS) begin
               m_fb[wr_if.wrAddr] = wr_if.wrData; m_known[wr_if.wrAddr] = 1;
            end else if (m_drop < 65535) m_drop++;
         end
         if (clear) begin m_busy = 1; m_clr = 0; end
      end
      if (clear) begin m_stall = 0; m_drop = 0; end
      act_h2 = act_h1; act_h1 = active;
      hs_h2 = hs_h1; hs_h1 = hs_in;
      vs_h2 = vs_h1; vs_h1 = vs_in;
      l_h2 = l_h1; l_h1 = l_cur; lk_h2 = lk_h1; lk_h1 = lk_cur;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int x, input int y, input bit act);
      px = 10'(x); py = 10'(y); active = act;
   endtask

   task automatic write_word(input int addr, input logic [8:0] data);
      drive(1, 0, 0);
      wr_if.wrValid = 1; wr_if.wrAddr = ADDR_W'(addr); wr_if.wrData = data;
      cycle();
      check("write_accepted", last_ready, 1'b1);
      wr_if.wrValid = 0;
   endtask

   typedef struct {
      int         x, y;
      bit         act;
      bit         exp_ready;
      logic [8:0] exp_rgb;
   } row_t;
   row_t rows[$];

   task automatic add_rows(input int y, input int x0, input int x1, input logic [8:0] lo_rgb,
                           input logic [8:0] hi_rgb, input int split);
      for (int x = x0; x <= x1; x++)
         rows.push_back('{x, y, 1'b1, (x % 4) != 0, (x < split) ? lo_rgb : hi_rgb});
   endtask

   initial begin
      int lows, highs, bad_ready, nonbg;
      model_reset();
      drive(1, 0, 1); hs_in = 1; vs_in = 1; clear = 0;
      wr_if.wrValid = 0; wr_if.wrAddr = '0; wr_if.wrData = '0;
      #12;
      // Reset state with active sync inputs toggling in.
      check("rst_hs", hs_out, 1'b0);
      check("rst_vs", vs_out, 1'b0);
      check("rst_rgb", {red, green, blue}, 9'h000);
      check("rst_busy", busy, 1'b1);
      check("rst_ready", wr_if.wrReady, 1'b0);
      @(posedge clk); #1;
      drive(0, 0, 0); hs_in = 0; vs_in = 0;
      rst_n = 1;

      // Test 1: clear after reset with random scan traffic and a writer that must be held off.
      bad_ready = 0;
      for (int n = 0; n < 40000 && m_busy; n++) begin
         drive($urandom_range(639, 0), $urandom_range(479, 0), ($urandom_range(3, 0) == 0));
         hs_in = 1'($urandom); vs_in = 1'($urandom);
         wr_if.wrValid = 1'($urandom); wr_if.wrAddr = ADDR_W'($urandom_range(WORDS - 1, 0));
         wr_if.wrData = 9'($urandom);
         cycle();
         if (last_ready && last_busy) bad_ready++;
      end
      check("ready_while_busy", bad_ready, 0);
      wr_if.wrValid = 0; hs_in = 0; vs_in = 0;
      drive(1, 0, 0);
      cycle();
      check("busy_after_clear", last_busy, 1'b0);

      // Test 2: two words, then a table of scan vectors (inputs plus expected outputs 2 clocks later).
      write_word(0, 9'h1FF);
      write_word(161, 9'h038);
      add_rows(0, 0, 7, 9'h1FF, 9'h000, 4);
      add_rows(3, 0, 4, 9'h1FF, 9'h000, 4);
      add_rows(4, 4, 8, 9'h038, 9'h000, 8);
      add_rows(7, 4, 7, 9'h038, 9'h000, 8);
      rows.push_back('{1, 0, 1'b0, 1'b1, 9'h000});
      rows.push_back('{1, 0, 1'b0, 1'b1, 9'h000});
      for (int i = 0; i < rows.size(); i++) begin
         drive(rows[i].x, rows[i].y, rows[i].act);
         cycle();
         check("tbl_ready", last_ready, rows[i].exp_ready);
         if (i >= 2) check("tbl_rgb", last_rgb, rows[i-2].exp_rgb);
      end

      // Test 3: writer valid for a full active line.
      lows = 0; highs = 0;
      wr_if.wrValid = 1;
      for (int x = 0; x < 640; x++) begin
         drive(x, 8, 1);
         wr_if.wrAddr = ADDR_W'($urandom_range(WORDS - 1, 2));
         wr_if.wrData = 9'($urandom);
         cycle();
         if (last_ready) highs++; else lows++;
      end
      wr_if.wrValid = 0;
      check("line_ready_low", lows, 160);
      check("line_ready_high", highs, 480);

      // Test 4: out-of-range write is accepted and dropped; word 0 still reads back.
      drive(1, 0, 0);
      wr_if.wrValid = 1; wr_if.wrAddr = ADDR_W'(WORDS); wr_if.wrData = 9'h1FF;
      cycle();
      check("oor_accepted", last_ready, 1'b1);
      wr_if.wrValid = 0;
      cycle();
`ifdef VGA_FB_ARB_STATS_EN
      check("drop_cnt_one", drop_cnt, 16'd1);
`endif
      drive(0, 0, 1); cycle();
      drive(1, 0, 1); cycle();
      drive(2, 0, 1); cycle();
      check("word0_kept", last_rgb, 9'h1FF);

      // Random traffic, including out-of-range writes.
      for (int n = 0; n < 3000; n++) begin
         drive($urandom_range(639, 0), $urandom_range(479, 0), 1'($urandom));
         hs_in = 1'($urandom); vs_in = 1'($urandom);
         wr_if.wrValid = 1'($urandom);
         wr_if.wrAddr = ($urandom_range(9, 0) == 0) ? ADDR_W'($urandom_range(32767, WORDS))
                                                   : ADDR_W'($urandom_range(WORDS - 1, 0));
         wr_if.wrData = 9'($urandom);
         cycle();
      end
      hs_in = 0; vs_in = 0;

      // Test 5: clear pulse coinciding with a writer handshake, a restart mid-clear, then full readback.
      drive(1, 40, 1);
      wr_if.wrValid = 1; wr_if.wrAddr = ADDR_W'(5); wr_if.wrData = 9'h155; clear = 1;
      cycle();
      check("clear_cycle_ready", last_ready, 1'b1);
      clear = 0;
      cycle();
      check("after_clear_ready", last_ready, 1'b0);
      check("after_clear_busy", last_busy, 1'b1);
      drive(1, 0, 0);
      for (int n = 0; n < 25000 && m_busy; n++) begin
         clear = (n == 100);
         cycle();
      end
      clear = 0; wr_if.wrValid = 0;
      cycle();
      check("clear2_done", last_busy, 1'b0);
      nonbg = 0;
      for (int w = 0; w < WORDS + 2; w++) begin
         if (w < WORDS) drive(4 * (w % FB_W), 4 * (w / FB_W), 1);
         else drive(1, 0, 0);
         cycle();
         if (w >= 2 && last_rgb != BG) nonbg++;
      end
      check("all_pixels_bg", nonbg, 0);

      // Test 6: asynchronous reset in the middle of a visible line.
      write_word(0, 9'h1FF);
      hs_in = 1; vs_in = 1;
      drive(0, 0, 1); cycle();
      drive(1, 0, 1); cycle();
      drive(2, 0, 1);
      #2;
      check("pre_rst_hs", hs_out, 1'b1);
      check("pre_rst_rgb", {red, green, blue}, 9'h1FF);
      rst_n = 0;
      #1;
      check("arst_hs", hs_out, 1'b0);
      check("arst_vs", vs_out, 1'b0);
      check("arst_rgb", {red, green, blue}, 9'h000);
      check("arst_ready", wr_if.wrReady, 1'b0);
      check("arst_busy", busy, 1'b1);
      @(posedge clk); @(posedge clk); #1;
      model_reset();
      rst_n = 1;
      for (int n = 0; n < 20; n++) begin
         drive(n, 0, 1);
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
